// File: rtl/dmem_arbiter.sv
// Data-memory sequencer shared by the CPU MEM stage and a debug port.
// Adds byte loads/stores on a word-only synchronous RAM (sb via read-modify-write).
module dmem_arbiter #(
  parameter int AW           = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_byte,
  input  logic          cpu_signed,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic [31:0]   dbg_rdata,
  output logic          dbg_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RMW  = 2'd2
  } state_t;

  function automatic logic [7:0] lane_get(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] lane_put(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      2'd3:    w[31:24] = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] lane,
                                           input logic is_byte, input logic sgn);
    logic [7:0]  b;
    logic [31:0] r;
    b = lane_get(word, lane);
    if (!is_byte) begin
      r = word;
    end else if (sgn) begin
      r = {{24{b[7]}}, b};
    end else begin
      r = {24'd0, b};
    end
    return r;
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_starve;
  logic          r_owner_dbg;
  logic          r_byte;
  logic          r_signed;
  logic [1:0]    r_lane;
  logic [7:0]    r_wbyte;
  logic [AW-1:0] r_addr;
  logic          r_dbg_wack;
  logic [31:0]   r_cpu_rdata;
  logic [31:0]   r_dbg_rdata;

  logic          w_idle;
  logic          w_dbg_valid;
  logic          w_dbg_win;
  logic          w_cpu_win;
  logic          w_starved;
  logic          w_mem_en;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [31:0]   w_mem_wdata;
  logic          w_stall;
  logic          w_rd_cpu;
  logic          w_rd_dbg;
  logic [31:0]   w_load_data;
  logic [AW-1:0] w_cpu_waddr;
  logic          w_unused_addr;

  assign w_cpu_waddr   = cpu_addr[AW+1:2];
  assign w_unused_addr = ^cpu_addr[31:AW+2];

  // The ack cycle of a DBG write still sees the old dbg_req, so it is not a new request.
  assign w_idle      = (r_state == S_IDLE);
  assign w_starved   = (r_starve == STARVE_MAX);
  assign w_dbg_valid = dbg_req & ~r_dbg_wack;
  assign w_dbg_win   = w_idle & w_dbg_valid & (~cpu_req | w_starved);
  assign w_cpu_win   = w_idle & cpu_req & ~w_dbg_win;

  assign w_rd_cpu    = (r_state == S_RD) & ~r_owner_dbg;
  assign w_rd_dbg    = (r_state == S_RD) & r_owner_dbg;
  assign w_load_data = load_fmt(mem_rdata, r_lane, r_byte, r_signed);

  // Next-state and memory command decode
  always_comb begin
    w_state_nxt = r_state;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = {AW{1'b0}};
    w_mem_wdata = 32'd0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dbg_win) begin
          w_mem_en    = 1'b1;
          w_mem_we    = dbg_we;
          w_mem_addr  = dbg_addr;
          w_mem_wdata = dbg_wdata;
          w_stall     = cpu_req;
          w_state_nxt = dbg_we ? S_IDLE : S_RD;
        end else if (w_cpu_win) begin
          w_mem_en   = 1'b1;
          w_mem_addr = w_cpu_waddr;
          if (cpu_we && !cpu_byte) begin
            w_mem_we    = 1'b1;
            w_mem_wdata = cpu_wdata;
          end else if (cpu_we) begin
            w_stall     = 1'b1;
            w_state_nxt = S_RMW;
          end else begin
            w_stall     = 1'b1;
            w_state_nxt = S_RD;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        w_stall     = r_owner_dbg ? cpu_req : 1'b0;
        w_state_nxt = S_IDLE;
      end
      S_RMW: begin
        w_mem_en    = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_addr;
        w_mem_wdata = lane_put(mem_rdata, r_lane, r_wbyte);
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held so an interrupted RMW never writes.
  assign mem_en    = reset & w_mem_en;
  assign mem_we    = reset & w_mem_we;
  assign mem_addr  = reset ? w_mem_addr : {AW{1'b0}};
  assign mem_wdata = reset ? w_mem_wdata : 32'd0;
  assign cpu_stall = reset & w_stall;
  assign cpu_rdata = w_rd_cpu ? w_load_data : r_cpu_rdata;
  assign dbg_rdata = w_rd_dbg ? mem_rdata : r_dbg_rdata;
  assign dbg_ack   = r_dbg_wack | w_rd_dbg;

  // State register and DBG write acknowledge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_dbg_wack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dbg_wack <= w_dbg_win & dbg_we;
    end
  end

  // Starvation counter: counts IDLE cycles in which DBG loses to the CPU
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= {SW{1'b0}};
    end else if (w_dbg_win) begin
      r_starve <= {SW{1'b0}};
    end else if (w_idle && w_dbg_valid && !w_starved) begin
      r_starve <= r_starve + {{(SW-1){1'b0}}, 1'b1};
    end else begin
      r_starve <= r_starve;
    end
  end

  // Capture the granted access so RD/RMW do not depend on requester inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner_dbg <= 1'b0;
      r_byte      <= 1'b0;
      r_signed    <= 1'b0;
      r_lane      <= 2'd0;
      r_wbyte     <= 8'd0;
      r_addr      <= {AW{1'b0}};
    end else if (w_dbg_win) begin
      r_owner_dbg <= 1'b1;
      r_byte      <= 1'b0;
      r_signed    <= 1'b0;
      r_lane      <= 2'd0;
      r_wbyte     <= 8'd0;
      r_addr      <= dbg_addr;
    end else if (w_cpu_win) begin
      r_owner_dbg <= 1'b0;
      r_byte      <= cpu_byte;
      r_signed    <= cpu_signed;
      r_lane      <= cpu_addr[1:0];
      r_wbyte     <= cpu_wdata[7:0];
      r_addr      <= w_cpu_waddr;
    end else begin
      r_owner_dbg <= r_owner_dbg;
      r_byte      <= r_byte;
      r_signed    <= r_signed;
      r_lane      <= r_lane;
      r_wbyte     <= r_wbyte;
      r_addr      <= r_addr;
    end
  end

  // Read-data holding registers keep the last returned value between loads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cpu_rdata <= 32'd0;
      r_dbg_rdata <= 32'd0;
    end else if (w_rd_cpu) begin
      r_cpu_rdata <= w_load_data;
      r_dbg_rdata <= r_dbg_rdata;
    end else if (w_rd_dbg) begin
      r_cpu_rdata <= r_cpu_rdata;
      r_dbg_rdata <= mem_rdata;
    end else begin
      r_cpu_rdata <= r_cpu_rdata;
      r_dbg_rdata <= r_dbg_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_dmem_arbiter;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_byte, cpu_signed;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_wdata, dbg_rdata;
  logic          dbg_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'd0;

  logic [31:0]   mem [0:255];

  logic [31:0]      exp_cpu [$];
  logic [31:0]      exp_dbg [$];
  logic [AW+31:0]   exp_wr  [$];
  logic [AW-1:0]    last_rd_addr = '0;
  int               ack_cnt = 0;
  int               errors = 0;
  int               checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte), .cpu_signed(cpu_signed),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // synchronous single-port RAM model
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none/other", nm);
  endtask

  // monitor: compare each DUT-presented result against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (mem_en && mem_we) begin
        if (exp_wr.size() == 0) fail_now("unexpected_mem_write");
        else chk("mem_write", {mem_addr, mem_wdata}, exp_wr.pop_front());
      end
      if (mem_en && !mem_we) last_rd_addr = mem_addr;
      if (cpu_req && !cpu_we && !cpu_stall) begin
        if (exp_cpu.size() == 0) fail_now("unexpected_cpu_load");
        else chk("cpu_rdata", cpu_rdata, exp_cpu.pop_front());
      end
      if (dbg_ack) begin
        ack_cnt++;
        if (exp_dbg.size() == 0) fail_now("unexpected_dbg_ack");
        else chk("dbg_rdata", dbg_rdata, exp_dbg.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns the number of stalled cycles.
  task automatic cpu_op(input logic we, input logic byt, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd, output int stalls);
    cpu_req = 1'b1; cpu_we = we; cpu_byte = byt; cpu_signed = sgn;
    cpu_addr = addr; cpu_wdata = wd;
    stalls = 0;
    @(negedge clk);
    while (cpu_stall && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    if (cpu_stall) fail_now("cpu_stall_timeout");
    @(posedge clk);
    #1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_signed = 1'b0;
  endtask

  task automatic dbg_op(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                        output int lat, output logic stall_at_ack);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
    lat = 0;
    @(negedge clk);
    while (!dbg_ack && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    if (!dbg_ack) fail_now("dbg_ack_timeout");
    stall_at_ack = cpu_stall;
    @(posedge clk);
    #1;
    dbg_req = 1'b0; dbg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   st;
    int   lat;
    int   st_last;
    logic sa;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[5] = 32'hdead0005;
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_signed = 1'b0;
    cpu_addr = 32'd0; cpu_wdata = 32'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = 32'd0;

    // reset and idle
    @(negedge clk);
    chk("reset_outputs", {cpu_rdata, dbg_rdata, dbg_ack, mem_en, mem_we, mem_addr, mem_wdata, cpu_stall}, 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_outputs", {cpu_rdata, dbg_rdata, dbg_ack, mem_en, mem_we, mem_addr, mem_wdata, cpu_stall}, 64'd0);
    end
    @(posedge clk); #1;

    // word store then load
    exp_wr.push_back({8'd2, 32'h04ee9112});
    cpu_op(1'b1, 1'b0, 1'b0, 32'h8, 32'h04ee9112, st);
    chk("sw_stall", st, 0);
    exp_cpu.push_back(32'h04ee9112);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h8, 32'h0, st);
    chk("lw_stall", st, 1);
    chk("lw_mem_addr", last_rd_addr, 8'd2);

    // byte store via RMW and byte loads on all edge lanes
    exp_wr.push_back({8'd6, 32'h11223344});
    cpu_op(1'b1, 1'b0, 1'b0, 32'h18, 32'h11223344, st);
    exp_wr.push_back({8'd6, 32'h1122ab44});
    cpu_op(1'b1, 1'b1, 1'b0, 32'h19, 32'h5a5a5aab, st);
    chk("sb_stall", st, 1);
    exp_cpu.push_back(32'hffffffab);
    cpu_op(1'b0, 1'b1, 1'b1, 32'h19, 32'h0, st);
    chk("lb_stall", st, 1);
    exp_cpu.push_back(32'h000000ab);
    cpu_op(1'b0, 1'b1, 1'b0, 32'h19, 32'h0, st);
    exp_cpu.push_back(32'h00000011);
    cpu_op(1'b0, 1'b1, 1'b1, 32'h1b, 32'h0, st);
    exp_cpu.push_back(32'h00000044);
    cpu_op(1'b0, 1'b1, 1'b0, 32'h18, 32'h0, st);
    // upper address bits wrap
    exp_cpu.push_back(32'h04ee9112);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h408, 32'h0, st);

    // DBG write then CPU reads it back
    exp_wr.push_back({8'd3, 32'h00000055});
    exp_dbg.push_back(32'h0);
    dbg_op(1'b1, 8'd3, 32'h55, lat, sa);
    chk("dbg_wr_latency", lat, 1);
    exp_cpu.push_back(32'h00000055);
    cpu_op(1'b0, 1'b0, 1'b0, 32'hc, 32'h0, st);

    // DBG read with idle CPU
    exp_dbg.push_back(32'hdead0005);
    dbg_op(1'b0, 8'd5, 32'h0, lat, sa);
    chk("dbg_rd_latency", lat, 1);
    chk("dbg_rd_idle_stall", sa, 1'b0);

    // DBG starved by back-to-back CPU loads
    exp_dbg.push_back(32'hdead0005);
    st_last = 0;
    fork
      begin
        int s;
        for (int k = 0; k < 5; k++) begin
          exp_cpu.push_back(32'h04ee9112);
          cpu_op(1'b0, 1'b0, 1'b0, 32'h8, 32'h0, s);
          st_last = s;
        end
      end
      begin
        int   l;
        logic a;
        dbg_op(1'b0, 8'd5, 32'h0, l, a);
        lat = l;
        sa  = a;
      end
    join
    chk("starve_latency", lat, 9);
    chk("starve_cpu_stalled", sa, 1'b1);
    chk("starve_last_cpu_stall", st_last, 3);

    // reset during the RMW cycle of an sb
    exp_wr.push_back({8'd8, 32'hcafef00d});
    cpu_op(1'b1, 1'b0, 1'b0, 32'h20, 32'hcafef00d, st);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b1; cpu_addr = 32'h21; cpu_wdata = 32'h77;
    @(negedge clk);
    chk("sb_idle_stall", cpu_stall, 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    #1 chk("rst_rmw_quiet", {mem_en, mem_we, cpu_stall, dbg_ack}, 64'd0);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0;
    @(negedge clk);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("rmw_word_unchanged", mem[8], 32'hcafef00d);
    exp_cpu.push_back(32'hcafef00d);
    cpu_op(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, st);
    chk("post_reset_lw_stall", st, 1);

    repeat (2) @(posedge clk);
    chk("dbg_ack_count", ack_cnt, 3);
    chk("scoreboard_empty", exp_cpu.size() + exp_dbg.size() + exp_wr.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
